// File: rtl/mips_data_mem.sv
// Single-port MIPS data memory with byte-lane writes and a streaming dump engine; reads return RD_LAT cycles after accept.
// Backpressure: mem_ready drops for the whole dump; dump words hold while dump_ready is low.
module mips_data_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_req,
    output logic                     mem_ready,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_wr_ena,
    input  logic [DATA_W/8-1:0]      mem_be,
    input  logic [DATA_W-1:0]        mem_wr_data,
    output logic [DATA_W-1:0]        mem_rd_data,
    output logic                     mem_rd_valid,
    input  logic                     dump_start,
    output logic                     dump_busy,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [$clog2(DEPTH)-1:0] dump_index,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_done
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_STREAM,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  word_idx;
    logic              accept;
    logic              wr_acc;
    logic              rd_acc;

    logic [RD_LAT-1:0] pipe_vld;
    logic [DATA_W-1:0] pipe_dat [RD_LAT];

    logic [IDX_W-1:0]  dump_idx;
    logic [IDX_W-1:0]  dump_idx_inc;
    logic              dump_vld;
    logic [DATA_W-1:0] dump_dat;
    logic              dump_last;

    // Address bits outside the word index are intentionally ignored (aliasing).
    logic [ADDR_W-1:0] addr_unused;
    assign addr_unused = mem_addr;

    assign word_idx  = mem_addr[OFF_W +: IDX_W];
    assign mem_ready = (state == S_IDLE) && !rst;
    assign accept    = mem_req && mem_ready;
    assign wr_acc    = accept && mem_wr_ena;
    assign rd_acc    = accept && !mem_wr_ena;

    // Array is never reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_be[i]) begin
                    mem[word_idx][8*i +: 8] <= mem_wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_dat[k] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_acc;
            if (rd_acc) begin
                pipe_dat[0] <= mem[word_idx];
            end
            // Data stages only advance behind a valid, so the output holds between pulses.
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                if (pipe_vld[k-1]) begin
                    pipe_dat[k] <= pipe_dat[k-1];
                end
            end
        end
    end

    assign mem_rd_valid = pipe_vld[RD_LAT-1];
    assign mem_rd_data  = pipe_dat[RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign dump_idx_inc = dump_idx + IDX_W'(1);
    assign dump_last    = (dump_idx == IDX_W'(DEPTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (dump_start) state_nxt = S_DRAIN;
            S_DRAIN:  if (pipe_vld == '0) state_nxt = S_STREAM;
            S_STREAM: if (dump_vld && dump_ready && dump_last) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // No CPU access can occur while streaming, so prefetching the next word is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dump_idx <= '0;
            dump_vld <= 1'b0;
            dump_dat <= '0;
        end else begin
            case (state)
                S_DRAIN: begin
                    dump_idx <= '0;
                    dump_vld <= 1'b0;
                end
                S_STREAM: begin
                    if (!dump_vld) begin
                        dump_dat <= mem[dump_idx];
                        dump_vld <= 1'b1;
                    end else if (dump_ready) begin
                        dump_idx <= dump_idx_inc;
                        if (dump_last) begin
                            dump_vld <= 1'b0;
                        end else begin
                            dump_dat <= mem[dump_idx_inc];
                        end
                    end
                end
                default: begin
                    dump_vld <= 1'b0;
                end
            endcase
        end
    end

    assign dump_busy  = (state != S_IDLE);
    assign dump_done  = (state == S_DONE);
    assign dump_valid = dump_vld;
    assign dump_index = dump_idx;
    assign dump_data  = dump_dat;

endmodule

// File: tb/tb_mips_data_mem.sv
// Bench for mips_data_mem: directed vector table, randomized traffic against a word-array model, and dump sequences.
module tb_mips_data_mem;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 16;
    localparam int RL    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_ena;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_valid;
    logic          dump_start;
    logic          dump_busy;
    logic          dump_valid;
    logic          dump_ready;
    logic [3:0]    dump_index;
    logic [DW-1:0] dump_data;
    logic          dump_done;

    mips_data_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wr_ena(mem_wr_ena), .mem_be(mem_be), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_index(dump_index), .dump_data(dump_data),
        .dump_done(dump_done)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        int          due;
    } rsp_t;

    logic [31:0] ref_mem [DEPTH];
    rsp_t        rq[$];
    logic [31:0] last_rd;
    int          cyc;
    bit          exp_ready;
    int          n_chk;
    int          n_fail;
    vec_t        tv [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // One clock: apply the model's view of this cycle's accept, then check outputs after the edge.
    task automatic tick();
        bit acc;
        bit dst;
        int idx;
        acc = mem_req && exp_ready;
        dst = dump_start && exp_ready;
        idx = int'((mem_addr / 4) % DEPTH);
        if (acc) begin
            if (mem_wr_ena) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ref_mem[idx][8*b +: 8] = mem_wr_data[8*b +: 8];
            end else begin
                rq.push_back('{d: ref_mem[idx], due: cyc + RL});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (dst) exp_ready = 1'b0;
        chk("mem_ready", 32'(mem_ready), 32'(exp_ready));
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("rd_valid", 32'(mem_rd_valid), 32'd1);
            chk("rd_data", mem_rd_data, rq[0].d);
            last_rd = rq[0].d;
            void'(rq.pop_front());
        end else begin
            chk("rd_valid_idle", 32'(mem_rd_valid), 32'd0);
            chk("rd_data_hold", mem_rd_data, last_rd);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_ready"}, 32'(mem_ready), 32'd0);
        chk({tag, "_rd_valid"}, 32'(mem_rd_valid), 32'd0);
        chk({tag, "_rd_data"}, mem_rd_data, 32'd0);
        chk({tag, "_dump_busy"}, 32'(dump_busy), 32'd0);
        chk({tag, "_dump_valid"}, 32'(dump_valid), 32'd0);
        chk({tag, "_dump_index"}, 32'(dump_index), 32'd0);
        chk({tag, "_dump_data"}, dump_data, 32'd0);
        chk({tag, "_dump_done"}, 32'(dump_done), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a);
        mem_req = 1'b1; mem_wr_ena = 1'b0; mem_addr = a;
        tick();
        mem_req = 1'b0;
        repeat (RL + 1) tick();
    endtask

    // Full dump with a request issued alongside dump_start; optional ready toggling and a mid-dump restart.
    task automatic run_dump(input bit toggle, input bit restart, input bit wr);
        int          nxt;
        int          dones;
        int          g;
        logic        v;
        logic        r;
        logic [3:0]  i;
        logic [31:0] d;
        nxt = 0; dones = 0; g = 0;
        mem_req = 1'b1; mem_wr_ena = wr; mem_addr = 32'h0C; mem_be = 4'hF; mem_wr_data = 32'h12345678;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        mem_req = restart; mem_wr_ena = 1'b1; mem_addr = 32'h0; mem_wr_data = 32'hFFFFFFFF;
        while (dones == 0 && g < 200) begin
            dump_ready = toggle ? g[0] : 1'b1;
            dump_start = restart && (g == 10);
            v = dump_valid; r = dump_ready; i = dump_index; d = dump_data;
            tick();
            g++;
            chk("dump_busy", 32'(dump_busy), 32'd1);
            if (v && r) begin
                chk("dump_index", 32'(i), 32'(nxt));
                chk("dump_data", d, ref_mem[nxt]);
                nxt++;
            end else if (v) begin
                chk("dump_hold_valid", 32'(dump_valid), 32'd1);
                chk("dump_hold_index", 32'(dump_index), 32'(i));
                chk("dump_hold_data", dump_data, d);
            end
            if (dump_done) begin
                dones++;
                chk("dump_count", 32'(nxt), 32'(DEPTH));
                chk("dump_valid_at_done", 32'(dump_valid), 32'd0);
            end
        end
        chk("dump_done_seen", 32'(dones), 32'd1);
        dump_start = 1'b0;
        mem_req = 1'b0;
        exp_ready = 1'b1;
        dump_ready = 1'b1;
        repeat (4) begin
            tick();
            chk("post_dump_done", 32'(dump_done), 32'd0);
            chk("post_dump_busy", 32'(dump_busy), 32'd0);
            chk("post_dump_valid", 32'(dump_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses;
        int g;
        n_chk = 0; n_fail = 0; cyc = 0; exp_ready = 1'b0; last_rd = '0;
        rst = 1'b1; mem_req = 1'b0; mem_addr = '0; mem_wr_ena = 1'b0; mem_be = '0;
        mem_wr_data = '0; dump_start = 1'b0; dump_ready = 1'b0;

        tv[0]  = '{1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0};
        tv[1]  = '{1'b0, 32'h10,   4'h0, 32'h0,        32'hDEADBEEF};
        tv[2]  = '{1'b1, 32'h20,   4'hF, 32'h11223344, 32'h0};
        tv[3]  = '{1'b1, 32'h20,   4'h5, 32'hAABBCCDD, 32'h0};
        tv[4]  = '{1'b0, 32'h20,   4'h0, 32'h0,        32'h11BB33DD};
        tv[5]  = '{1'b1, 32'h40,   4'hF, 32'h00000005, 32'h0};
        tv[6]  = '{1'b0, 32'h00,   4'h0, 32'h0,        32'h00000005};
        tv[7]  = '{1'b1, 32'h24,   4'hF, 32'h0BADF00D, 32'h0};
        tv[8]  = '{1'b1, 32'h24,   4'h0, 32'hFFFFFFFF, 32'h0};
        tv[9]  = '{1'b0, 32'h24,   4'h0, 32'h0,        32'h0BADF00D};
        tv[10] = '{1'b0, 32'h13,   4'h0, 32'h0,        32'hDEADBEEF};
        tv[11] = '{1'b1, 32'h7C,   4'hF, 32'hCAFEF00D, 32'h0};
        tv[12] = '{1'b0, 32'h3C,   4'h0, 32'h0,        32'hCAFEF00D};
        tv[13] = '{1'b0, 32'h1002, 4'h0, 32'h0,        32'h00000005};
        tv[14] = '{1'b1, 32'h20,   4'h8, 32'h99000000, 32'h0};
        tv[15] = '{1'b0, 32'h20,   4'h0, 32'h0,        32'h99BB33DD};

        #3;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        exp_ready = 1'b1;
        #1;
        chk("ready_after_release", 32'(mem_ready), 32'd1);

        for (int t = 0; t < 16; t++) begin
            mem_req = 1'b1; mem_wr_ena = tv[t].wr; mem_addr = tv[t].addr;
            mem_be = tv[t].be; mem_wr_data = tv[t].wdat;
            tick();
            mem_req = 1'b0;
            if (!tv[t].wr) begin
                repeat (RL - 1) tick();
                chk("vec_rd_valid", 32'(mem_rd_valid), 32'd1);
                chk("vec_rd_data", mem_rd_data, tv[t].exp);
            end
        end

        pulses = 0;
        for (int k = 0; k < 4 + RL + 1; k++) begin
            mem_req = (k < 4); mem_wr_ena = 1'b0;
            case (k)
                0: mem_addr = 32'h10;
                1: mem_addr = 32'h20;
                2: mem_addr = 32'h00;
                default: mem_addr = 32'h3C;
            endcase
            tick();
            pulses += int'(mem_rd_valid);
        end
        chk("b2b_pulses", 32'(pulses), 32'd4);

        for (int w = 0; w < DEPTH; w++) begin
            mem_req = 1'b1; mem_wr_ena = 1'b1; mem_addr = 32'(w * 4);
            mem_be = 4'hF; mem_wr_data = 32'(32'h100 + w);
            tick();
        end
        mem_req = 1'b0;
        tick();
        run_dump(1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 300; k++) begin
            mem_req = ($urandom_range(0, 3) != 0);
            mem_wr_ena = $urandom_range(0, 1);
            mem_addr = $urandom;
            mem_be = 4'($urandom);
            mem_wr_data = $urandom;
            tick();
        end
        mem_req = 1'b0;
        repeat (RL + 1) tick();
        chk("rand_queue_empty", 32'(rq.size()), 32'd0);

        run_dump(1'b1, 1'b1, 1'b0);
        do_read(32'h0);

        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        g = 0;
        while (!(dump_valid && dump_index == 4'd3) && g < 50) begin
            tick();
            g++;
        end
        chk("abort_reached_idx3", 32'(dump_valid && dump_index == 4'd3), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        rq.delete();
        last_rd = '0;
        exp_ready = 1'b0;
        repeat (2) begin
            tick();
            chk("abort_no_done", 32'(dump_done), 32'd0);
        end
        rst = 1'b0;
        exp_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("abort_after_done", 32'(dump_done), 32'd0);
            chk("abort_after_busy", 32'(dump_busy), 32'd0);
        end
        do_read(32'h14);
        do_read(32'h0C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
